// File: rtl/pe_layer_seq.sv
// Multi-channel 3x3 conv PE: per-beat MAC tree (S1), channel accumulate + bias + ReLU (S2).
// Optional output clamp to the signed OUT_W maximum when PE_LAYER_SEQ_SAT_EN is defined.
module pe_layer_seq #(
  parameter int DATA_W   = 9,
  parameter int WEIGHT_W = 16,
  parameter int BIAS_W   = 16,
  parameter int TAPS     = 9,
  parameter int CH_NUM   = 3,
  parameter int ACC_W    = 36,
  parameter int OUT_W    = 36
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [TAPS*DATA_W-1:0]     in_pix,
  input  logic [TAPS*WEIGHT_W-1:0]   in_weight,
  input  logic [BIAS_W-1:0]          in_bias,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic                       busy
);

  localparam int CNT_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t LAST_CH = cnt_t'(CH_NUM - 1);

  logic                     stall;
  logic                     accept;
  logic                     first_ch;
  logic                     last_ch;

  cnt_t                     ch_cnt_q,   ch_cnt_d;
  logic                     s1_valid_q, s1_valid_d;
  logic                     s1_last_q,  s1_last_d;
  logic signed [ACC_W-1:0]  s1_psum_q,  s1_psum_d;
  logic signed [BIAS_W-1:0] s1_bias_q,  s1_bias_d;
  logic signed [ACC_W-1:0]  acc_q,      acc_d;
  logic                     out_valid_q, out_valid_d;
  logic [OUT_W-1:0]         out_data_q,  out_data_d;

  logic signed [ACC_W-1:0]  pix_x;
  logic signed [ACC_W-1:0]  wgt_x;
  logic signed [ACC_W-1:0]  psum;
  logic signed [ACC_W-1:0]  total;
  logic signed [ACC_W-1:0]  relu;
  logic [OUT_W-1:0]         out_val;

  // Tap products summed at full accumulator width; operands sign-extended first.
  always_comb begin
    psum  = '0;
    pix_x = '0;
    wgt_x = '0;
    for (int unsigned i = 0; i < TAPS; i++) begin
      pix_x = ACC_W'($signed(in_pix[i*DATA_W +: DATA_W]));
      wgt_x = ACC_W'($signed(in_weight[i*WEIGHT_W +: WEIGHT_W]));
      psum  = psum + pix_x * wgt_x;
    end
  end

  always_comb begin
    total = acc_q + s1_psum_q + ACC_W'(s1_bias_q);
    relu  = total[ACC_W-1] ? '0 : total;
  end

`ifdef PE_LAYER_SEQ_SAT_EN
  localparam logic signed [ACC_W-1:0] OUT_MAX =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};

  always_comb begin
    out_val = (relu > OUT_MAX) ? OUT_W'(OUT_MAX) : OUT_W'(relu);
  end
`else
  always_comb begin
    out_val = OUT_W'(relu);
  end
`endif

  always_comb begin
    stall    = out_valid_q && !out_ready;
    accept   = in_valid && !stall;
    first_ch = (ch_cnt_q == '0);
    last_ch  = (ch_cnt_q == LAST_CH);

    ch_cnt_d    = ch_cnt_q;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    s1_psum_d   = s1_psum_q;
    s1_bias_d   = s1_bias_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    // Whole pipeline advances together; a stall freezes every stage.
    if (!stall) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_psum_d = psum;
        s1_last_d = last_ch;
        // Bias captured on channel 0 and held for the rest of the group.
        s1_bias_d = first_ch ? $signed(in_bias) : s1_bias_q;
        ch_cnt_d  = last_ch ? '0 : cnt_t'(ch_cnt_q + 1'b1);
      end

      out_valid_d = s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        if (s1_last_q) begin
          acc_d      = '0;
          out_data_d = out_val;
        end else begin
          acc_d = acc_q + s1_psum_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch_cnt_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_psum_q   <= '0;
      s1_bias_q   <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      ch_cnt_q    <= ch_cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_psum_q   <= s1_psum_d;
      s1_bias_q   <= s1_bias_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = !stall;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (ch_cnt_q != '0) || s1_valid_q;

endmodule
